// File: rtl/instruction_fetch_sequencer.sv
// Fetches one 16-bit instruction as two byte reads and writes it into the IR.
// Define FETCH_TIMEOUT_EN to abort a read after TIMEOUT wait cycles.
module instruction_fetch_sequencer #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              PCLoad,
  input  logic [ADDR_W-1:0] PCIn,
  output logic              MemRead,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemValid,
  input  logic [7:0]        MemData,
  output logic              IRWrite,
  output logic              IRLH,
  output logic [7:0]        IRData,
  output logic [ADDR_W-1:0] PCOut,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    WR_LO,
    RD_HI,
    WR_HI
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic              done_q, done_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [ADDR_W-1:0] start_q, start_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      done_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      start_q <= RESET_PC;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      done_q  <= done_d;
`ifdef FETCH_TIMEOUT_EN
      start_q <= start_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    done_d  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    start_d = start_q;
    cnt_d   = '0;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (PCLoad) pc_d = PCIn;
        if (Start) begin
`ifdef FETCH_TIMEOUT_EN
          start_d = PCLoad ? PCIn : pc_q;
`endif
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        if (MemValid) begin
          ir_d    = MemData;
          state_d = WR_LO;
        end
      end
      WR_LO: begin
        pc_d    = pc_q + 1'b1;
        state_d = RD_HI;
      end
      RD_HI: begin
        if (MemValid) begin
          ir_d    = MemData;
          state_d = WR_HI;
        end
      end
      WR_HI: begin
        pc_d    = pc_q + 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef FETCH_TIMEOUT_EN
    // Counter is zero on entry to either read state since WR_LO/IDLE clear it.
    if ((state_q == RD_LO || state_q == RD_HI) && !MemValid) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d = IDLE;
        pc_d    = start_q;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  assign MemRead = (state_q == RD_LO) || (state_q == RD_HI);
  assign MemAddr = MemRead ? pc_q : '0;
  assign IRWrite = (state_q == WR_LO) || (state_q == WR_HI);
  assign IRLH    = (state_q == WR_HI);
  assign Busy    = (state_q != IDLE);
  assign IRData  = ir_q;
  assign PCOut   = pc_q;
  assign Done    = done_q;
`ifdef FETCH_TIMEOUT_EN
  assign Error   = err_q;
`else
  assign Error   = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Randomized scoreboard bench for instruction_fetch_sequencer.
// Memory responder, reference model and monitor run as separate processes.
module tb_instruction_fetch_sequencer;

  typedef struct {
    int         cyc;
    logic       lh;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    int          cyc;
    logic [15:0] pc;
    logic [15:0] instr;
  } done_t;

  typedef struct {
    int          cyc;
    logic [15:0] pc;
  } err_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_in = '0;
  logic        mem_read;
  logic [15:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [7:0]  mem_data = '0;
  logic        ir_write;
  logic        ir_lh;
  logic [7:0]  ir_data;
  logic [15:0] pc_out;
  logic        busy;
  logic        done;
  logic        error;

  logic [7:0]  mem [65536];
  logic [15:0] model_pc = '0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic [15:0] addr_q [$];
  int          wait_q [$];
  wr_t         wr_q [$];
  done_t       done_q [$];
  err_t        err_q [$];

  instruction_fetch_sequencer #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .Clock    (clk),
    .Reset    (rst_n),
    .Start    (start),
    .PCLoad   (pc_load),
    .PCIn     (pc_in),
    .MemRead  (mem_read),
    .MemAddr  (mem_addr),
    .MemValid (mem_valid),
    .MemData  (mem_data),
    .IRWrite  (ir_write),
    .IRLH     (ir_lh),
    .IRData   (ir_data),
    .PCOut    (pc_out),
    .Busy     (busy),
    .Done     (done),
    .Error    (error)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (cyc %0d)", name, cyc);
  endtask

  // Memory: per-read wait count taken from wait_q; junk valid outside reads.
  initial begin
    bit active;
    int left;
    active = 0;
    left = 0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_read) begin
        if (!active) begin
          active = 1;
          left = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
        end
        if (left == 0) begin
          mem_valid = 1'b1;
          mem_data  = mem[mem_addr];
        end else begin
          mem_valid = 1'b0;
          mem_data  = 8'($urandom);
          left--;
        end
      end else begin
        active    = 0;
        mem_valid = 1'($urandom_range(0, 1));
        mem_data  = 8'($urandom);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    bit          prev_rd;
    logic [15:0] ir;
    wr_t         w;
    done_t       d;
    err_t        e;
    prev_rd = 0;
    ir = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_read && !prev_rd) begin
          if (addr_q.size() == 0) flag("mem_read");
          else check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
        end
        if (ir_write) begin
          if (ir_lh) ir[15:8] = ir_data;
          else ir[7:0] = ir_data;
          if (wr_q.size() == 0) flag("ir_write");
          else begin
            w = wr_q.pop_front();
            check("wr_cyc", 32'(cyc), 32'(w.cyc));
            check("wr_lh", 32'(ir_lh), 32'(w.lh));
            check("wr_data", 32'(ir_data), 32'(w.data));
          end
        end
        if (done) begin
          if (done_q.size() == 0) flag("done");
          else begin
            d = done_q.pop_front();
            check("done_cyc", 32'(cyc), 32'(d.cyc));
            check("done_pc", 32'(pc_out), 32'(d.pc));
            check("ir_value", 32'(ir), 32'(d.instr));
          end
        end
        if (error) begin
          if (err_q.size() == 0) flag("error");
          else begin
            e = err_q.pop_front();
            check("err_cyc", 32'(cyc), 32'(e.cyc));
            check("err_pc", 32'(pc_out), 32'(e.pc));
            check("err_busy", 32'(busy), 32'd0);
          end
        end
      end
      prev_rd = mem_read;
    end
  end

  // Called at a negedge while idle; returns at the negedge of the Done cycle.
  // junk: 0 none, 1 random Start/PCLoad while busy, 2 Start+PCLoad to 0x0500.
  task automatic do_fetch(input bit load, input logic [15:0] pcin,
                          input int w0, input int w1, input int junk);
    int s, dc;
    logic [15:0] lo, hi;
    if (load) model_pc = pcin;
    s  = cyc + 1;
    lo = model_pc;
    hi = lo + 16'd1;
    dc = s + 4 + w0 + w1;
    addr_q.push_back(lo);
    addr_q.push_back(hi);
    wait_q.push_back(w0);
    wait_q.push_back(w1);
    wr_q.push_back('{s + 1 + w0, 1'b0, mem[lo]});
    wr_q.push_back('{s + 3 + w0 + w1, 1'b1, mem[hi]});
    done_q.push_back('{dc, lo + 16'd2, {mem[hi], mem[lo]}});
    model_pc = lo + 16'd2;
    start   = 1'b1;
    pc_load = load;
    pc_in   = pcin;
    @(negedge clk);
    while (cyc < dc) begin
      check("busy_hi", 32'(busy), 32'd1);
      if (junk == 2) begin
        start = 1'b1; pc_load = 1'b1; pc_in = 16'h0500;
      end else if (junk == 1) begin
        start   = 1'($urandom_range(0, 1));
        pc_load = 1'($urandom_range(0, 1));
        pc_in   = 16'($urandom);
      end else begin
        start = 1'b0; pc_load = 1'b0;
      end
      @(negedge clk);
    end
    start   = 1'b0;
    pc_load = 1'b0;
    check("busy_done", 32'(busy), 32'd0);
  endtask

  task automatic idle(input int n, input bit load, input logic [15:0] pcin);
    for (int i = 0; i < n; i++) begin
      pc_load = load;
      pc_in   = pcin;
      if (load) model_pc = pcin;
      @(negedge clk);
    end
    pc_load = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish by 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h34;
    mem[1] = 8'h12;

    repeat (2) @(negedge clk);
    check("rst_pc", 32'(pc_out), 32'h0);
    check("rst_rd", 32'(mem_read), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_irdata", 32'(ir_data), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_fetch(1'b0, 16'h0, 0, 0, 0);
    check("pc_after_first", 32'(pc_out), 32'h0002);
    idle(2, 1'b0, 16'h0);
    do_fetch(1'b1, 16'h0100, 3, 3, 0);
    check("pc_after_load", 32'(pc_out), 32'h0102);
    idle(1, 1'b1, 16'hFFFF);
    do_fetch(1'b0, 16'h0, 1, 0, 0);
    check("pc_after_wrap", 32'(pc_out), 32'h0001);
    do_fetch(1'b0, 16'h0, 0, 2, 2);
    check("pc_ignore", 32'(pc_out), 32'h0003);
`ifndef FETCH_TIMEOUT_EN
    do_fetch(1'b0, 16'h0, 20, 17, 1);
`endif

    for (int n = 0; n < 50; n++) begin
      idle($urandom_range(0, 2), 1'($urandom_range(0, 1)), 16'($urandom));
      do_fetch(1'($urandom_range(0, 1)), 16'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1));
    end

`ifdef FETCH_TIMEOUT_EN
    idle(1, 1'b1, 16'h0040);
    s = cyc + 1;
    addr_q.push_back(16'h0040);
    wait_q.push_back(1000);
    err_q.push_back('{s + 15, 16'h0040});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 15) @(negedge clk);
    @(negedge clk);
    check("to_busy", 32'(busy), 32'd0);
    check("to_pc", 32'(pc_out), 32'h0040);
`endif

    s = cyc + 1;
    addr_q.push_back(model_pc);
    addr_q.push_back(model_pc + 16'd1);
    wait_q.push_back(0);
    wait_q.push_back(5);
    wr_q.push_back('{s + 1, 1'b0, mem[model_pc]});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rd", 32'(mem_read), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'h0);
    check("arst_wr", 32'(ir_write), 32'd0);
    check("arst_irdata", 32'(ir_data), 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pc", 32'(pc_out), 32'h0);
    wait_q.delete();
    model_pc = 16'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(8, 1'b0, 16'h0);
    do_fetch(1'b0, 16'h0, 0, 1, 0);
    idle(4, 1'b0, 16'h0);

    check("addr_q_left", 32'(addr_q.size()), 32'd0);
    check("wr_q_left", 32'(wr_q.size()), 32'd0);
    check("done_q_left", 32'(done_q.size()), 32'd0);
    check("err_q_left", 32'(err_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
